// File: rtl/gpu_sched_pkg.sv
// Shared types and layer register field positions for the raster scheduler.
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    HAND = 3'd3,
    DONE = 3'd4
  } sched_state_t;

  localparam int LR_POPULATED_BIT = 0;
  localparam int LR_SPRITE_BIT    = 1;
  localparam int LR_VISIBLE_BIT   = 2;
  localparam int LAYER_REG_W      = 128;

  // A layer takes part in the raster only when it is both populated and visible.
  function automatic logic layer_enabled(input logic [LAYER_REG_W-1:0] word);
    return word[LR_POPULATED_BIT] & word[LR_VISIBLE_BIT];
  endfunction

endpackage

// File: rtl/layer_priority_finder.sv
// Combinational search for the first enabled layer at (optionally) or above a start index.
module layer_priority_finder #(
  parameter int NUM_LAYERS = 8,
  parameter int L_W        = 3
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [L_W-1:0]        start,
  input  logic                  include_start,
  output logic                  found,
  output logic [L_W-1:0]        index,
  output logic                  last
);

  // Scan from the top down so the lowest qualifying layer is the one left standing;
  // "last" reports that nothing enabled sits above the chosen index.
  always_comb begin
    found = 1'b0;
    index = '0;
    last  = 1'b1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(start)) || (include_start && (i == int'(start))))) begin
        found = 1'b1;
        index = L_W'(i);
      end
    end
    if (found) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (mask[i] && (i > int'(index))) last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/layer_raster_scheduler.sv
// Walks the raster (x fastest, then y) and every enabled layer per pixel, pulsing
// pipeline_clk low for one cycle per slot and handing each finished slot downstream.
//
// Handshake: out_valid rises only in HAND and holds, together with every slot field,
// until the cycle where out_valid && out_ready are both high; that cycle is the accept.
module layer_raster_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int  HOR_PIX    = 480,
  parameter int  VER_PIX    = 272,
  parameter int  NUM_LAYERS = 8,
  localparam int X_DEPTH    = $clog2(HOR_PIX),
  localparam int Y_DEPTH    = $clog2(VER_PIX),
  localparam int L_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  input  logic [NUM_LAYERS*LAYER_REG_W-1:0] layer_regs,
  input  logic                              alu_rdy,
  input  logic                              out_ready,
  output logic                              pipeline_clk,
  output logic [LAYER_REG_W-1:0]            layer_regs_sel,
  output logic [X_DEPTH:0]                  x_pixel,
  output logic [Y_DEPTH:0]                  y_pixel,
  output logic [L_W-1:0]                    layer_idx,
  output logic                              out_valid,
  output logic                              out_last,
  output logic                              out_bg,
  output logic                              busy,
  output logic                              frame_done,
  output logic [2:0]                        state_dbg
);

  localparam logic [X_DEPTH:0] X_MAX = (X_DEPTH + 1)'(HOR_PIX - 1);
  localparam logic [Y_DEPTH:0] Y_MAX = (Y_DEPTH + 1)'(VER_PIX - 1);

  sched_state_t          state, state_n;
  logic [NUM_LAYERS-1:0] live_mask, mask_q, lowest_mask;
  logic                  bg_q, calc_arm;
  logic                  lowest_found, next_found, frame_end;
  logic [L_W-1:0]        lowest_idx, next_idx;
  logic                  lowest_last_unused, next_last_unused;

  // Enable bits decoded from the live register file; only sampled at frame start.
  always_comb begin
    live_mask = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      live_mask[i] = layer_enabled(layer_regs[i*LAYER_REG_W +: LAYER_REG_W]);
    end
  end

  assign lowest_mask    = (state == IDLE) ? live_mask : mask_q;
  assign layer_regs_sel = layer_regs[int'(layer_idx)*LAYER_REG_W +: LAYER_REG_W];
  assign frame_end      = (x_pixel == X_MAX) && (y_pixel == Y_MAX);
  assign state_dbg      = state;

  layer_priority_finder #(.NUM_LAYERS(NUM_LAYERS), .L_W(L_W)) u_lowest (
    .mask          (lowest_mask),
    .start         ('0),
    .include_start (1'b1),
    .found         (lowest_found),
    .index         (lowest_idx),
    .last          (lowest_last_unused)
  );

  layer_priority_finder #(.NUM_LAYERS(NUM_LAYERS), .L_W(L_W)) u_next (
    .mask          (mask_q),
    .start         (layer_idx),
    .include_start (1'b0),
    .found         (next_found),
    .index         (next_idx),
    .last          (next_last_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_n      = state;
    pipeline_clk = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_bg       = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: if (frame_start) state_n = LOAD;
      LOAD: begin
        busy    = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        busy         = 1'b1;
        pipeline_clk = 1'b1;
        // First CALC cycle may still see rdy from the previous slot, so it is skipped.
        if (calc_arm && (bg_q || alu_rdy)) state_n = HAND;
      end
      HAND: begin
        busy         = 1'b1;
        pipeline_clk = 1'b1;
        out_valid    = 1'b1;
        out_last     = bg_q | ~next_found;
        out_bg       = bg_q;
        if (out_ready) state_n = (out_last && frame_end) ? DONE : LOAD;
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Slot datapath: frame mask snapshot, raster counters and layer walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_pixel   <= '0;
      y_pixel   <= '0;
      layer_idx <= '0;
      mask_q    <= '0;
      bg_q      <= 1'b0;
      calc_arm  <= 1'b0;
    end else begin
      calc_arm <= (state == CALC);
      case (state)
        IDLE: begin
          if (frame_start) begin
            mask_q    <= live_mask;
            x_pixel   <= '0;
            y_pixel   <= '0;
            layer_idx <= lowest_idx;
            bg_q      <= ~lowest_found;
          end
        end
        HAND: begin
          if (out_ready) begin
            if (!out_last) begin
              layer_idx <= next_idx;
            end else begin
              if (!frame_end) begin
                if (x_pixel == X_MAX) begin
                  x_pixel <= '0;
                  y_pixel <= y_pixel + {{Y_DEPTH{1'b0}}, 1'b1};
                end else begin
                  x_pixel <= x_pixel + {{X_DEPTH{1'b0}}, 1'b1};
                end
              end
              layer_idx <= lowest_idx;
            end
          end
        end
        DONE: begin
          x_pixel   <= '0;
          y_pixel   <= '0;
          layer_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_raster_scheduler.sv
// Directed bench for layer_raster_scheduler on a 4x2 screen with 4 layers.
module tb_layer_raster_scheduler;

  localparam int HOR = 4;
  localparam int VER = 2;
  localparam int NL  = 4;
  localparam int W   = 9;   // {x[2:0], y[1:0], layer[1:0], last, bg}

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic [NL*128-1:0] regs;
  logic            alu_rdy;
  logic            out_ready;
  logic            pipeline_clk;
  logic [127:0]    layer_regs_sel;
  logic [2:0]      x_pixel;
  logic [1:0]      y_pixel;
  logic [1:0]      layer_idx;
  logic            out_valid, out_last, out_bg, busy, frame_done;
  logic [2:0]      state_dbg;

  logic [W-1:0]    exp_q[$];
  int              vectors = 0;
  int              miscompares = 0;
  bit              rand_rdy = 0;
  bit              rand_ordy = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  layer_raster_scheduler #(.HOR_PIX(HOR), .VER_PIX(VER), .NUM_LAYERS(NL)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .layer_regs     (regs),
    .alu_rdy        (alu_rdy),
    .out_ready      (out_ready),
    .pipeline_clk   (pipeline_clk),
    .layer_regs_sel (layer_regs_sel),
    .x_pixel        (x_pixel),
    .y_pixel        (y_pixel),
    .layer_idx      (layer_idx),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_bg         (out_bg),
    .busy           (busy),
    .frame_done     (frame_done),
    .state_dbg      (state_dbg)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_of();
    logic [3:0] m;
    for (int i = 0; i < NL; i++) m[i] = regs[i*128] & regs[i*128+2];
    return m;
  endfunction

  // Random register word with the populated/visible bits forced to en.
  function automatic logic [127:0] make_word(input bit en);
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[0] = en;
    w[2] = en;
    return w;
  endfunction

  // Reference raster walk for one frame.
  task automatic push_frame(input logic [3:0] m);
    for (int yy = 0; yy < VER; yy++) begin
      for (int xx = 0; xx < HOR; xx++) begin
        if (m == 4'b0) begin
          exp_q.push_back({3'(xx), 2'(yy), 2'b00, 1'b1, 1'b1});
        end else begin
          for (int l = 0; l < NL; l++) begin
            if (m[l]) exp_q.push_back({3'(xx), 2'(yy), 2'(l), ((m >> (l + 1)) == 4'b0), 1'b0});
          end
        end
      end
    end
  endtask

  // Called at a negedge where the coming posedge accepts the slot.
  task automatic check_slot();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_slot", 128'd1, 128'd0);
    end else begin
      e = exp_q.pop_front();
      chk("slot_fields", {x_pixel, y_pixel, layer_idx, out_last, out_bg}, e);
      chk("layer_regs_sel", layer_regs_sel, regs[int'(e[3:2])*128 +: 128]);
    end
  endtask

  task automatic kick();
    @(negedge clk);
    frame_start = 1'b1;
  endtask

  // Runs until frame_done (bounded); optionally pokes layer 2 enable and frame_start mid-frame.
  task automatic run_frame(input int max_cyc, input int poke_cyc,
                           output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      frame_start = (c == poke_cyc);
      if (c == poke_cyc) begin
        regs[2*128]     = 1'b1;
        regs[2*128 + 2] = 1'b1;
      end
      if (rand_rdy)  alu_rdy   = 1'($urandom_range(0, 1));
      if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
      if (busy) busy_cyc++;
      if (frame_done) done_cnt++;
      if (out_valid && out_ready) check_slot();
      if (done_cnt > 0) break;
    end
    frame_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
    end
  endtask

  initial begin
    int bc, dc;
    bit hit;
    rst = 1'b0; frame_start = 1'b0; alu_rdy = 1'b0; out_ready = 1'b0; regs = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_pipeline_clk", pipeline_clk, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_coords", {x_pixel, y_pixel, layer_idx}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Frame A: no layers enabled, background slots at minimum cost.
    out_ready = 1'b1;
    push_frame(4'b0000);
    kick();
    run_frame(500, -1, bc, dc);
    chk("a_busy_cycles", 128'(bc), 128'd32);
    chk("a_frame_done_pulses", 128'(dc), 128'd1);
    chk("a_queue_empty", 128'(exp_q.size()), 128'd0);

    // Frame B: layers 1 and 3, random out_ready; layer 2 enabled and frame_start mid-frame.
    regs[0*128 +: 128] = make_word(0);
    regs[1*128 +: 128] = make_word(1);
    regs[2*128 +: 128] = make_word(0);
    regs[3*128 +: 128] = make_word(1);
    alu_rdy = 1'b1;
    rand_ordy = 1;
    push_frame(mask_of());
    kick();
    run_frame(2000, 20, bc, dc);
    chk("b_frame_done_pulses", 128'(dc), 128'd1);
    chk("b_queue_empty", 128'(exp_q.size()), 128'd0);

    // Frame C: layers 1,2,3 now; directed alu_rdy stall and out_ready backpressure on first slot.
    rand_ordy = 0;
    alu_rdy = 1'b0;
    out_ready = 1'b0;
    push_frame(mask_of());
    chk("c_mask_has_layer2", mask_of(), 4'b1110);
    kick();
    @(negedge clk);
    frame_start = 1'b0;
    chk("c_load_pclk", pipeline_clk, 0);
    chk("c_load_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("c_calc_pclk", pipeline_clk, 1);
      chk("c_calc_no_valid", out_valid, 0);
    end
    alu_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) alu_rdy = 1'b0;
      chk("c_hand_valid", out_valid, 1);
      chk("c_hand_pclk", pipeline_clk, 1);
      chk("c_hand_hold", {x_pixel, y_pixel, layer_idx, out_last, out_bg}, exp_q[0]);
      if (k == 3) begin
        out_ready = 1'b1;
        check_slot();
      end
    end
    @(negedge clk);
    chk("c_next_load_pclk", pipeline_clk, 0);
    chk("c_next_load_valid", out_valid, 0);
    rand_rdy = 1;
    rand_ordy = 1;
    run_frame(3000, -1, bc, dc);
    chk("c_frame_done_pulses", 128'(dc), 128'd1);
    chk("c_queue_empty", 128'(exp_q.size()), 128'd0);

    // Frame D: asynchronous reset at pixel (2,1).
    rand_rdy = 0;
    rand_ordy = 0;
    out_ready = 1'b1;
    regs = '0;
    push_frame(4'b0000);
    kick();
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (out_valid && x_pixel == 3'd2 && y_pixel == 2'd1) begin
        hit = 1;
        break;
      end
      if (out_valid && out_ready) check_slot();
    end
    chk("d_reached_2_1", hit, 1);
    #2 rst = 1'b0;
    #1;
    chk("d_rst_valid", out_valid, 0);
    chk("d_rst_pclk", pipeline_clk, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_coords", {x_pixel, y_pixel, layer_idx}, 0);
    exp_q.delete();
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) dc++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) dc++;
    end
    chk("d_no_frame_done", 128'(dc), 128'd0);

    // Frame E: restart after reset with layers 0 and 3.
    regs[0*128 +: 128] = make_word(1);
    regs[1*128 +: 128] = make_word(0);
    regs[2*128 +: 128] = make_word(0);
    regs[3*128 +: 128] = make_word(1);
    rand_rdy = 1;
    rand_ordy = 1;
    push_frame(mask_of());
    kick();
    run_frame(3000, -1, bc, dc);
    chk("e_frame_done_pulses", 128'(dc), 128'd1);
    chk("e_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_raster_scheduler.md
Name: layer_raster_scheduler

Overview:
- Sequences the per-pixel address-calculation pipeline stage.
- Walks the screen raster (x fastest, then y) and, for each pixel, every enabled layer in ascending index order.
- Per slot: selects that layer's 128-bit register word, drives pixel coordinates, and generates the pipeline_clk restart pulse for the address units.
- Waits for alu_rdy, then hands the slot downstream with a valid/ready handshake.

Parameters:
- HOR_PIX, 480, screen width in pixels
- VER_PIX, 272, screen height in pixels
- NUM_LAYERS, 8, number of layer register words
- X_DEPTH, $clog2(HOR_PIX), derived; x port MSB index
- Y_DEPTH, $clog2(VER_PIX), derived; y port MSB index
- L_W, $clog2(NUM_LAYERS) (min 1), derived layer index width

Ports:
- clk  in  1  system clock, 50 MHz max
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; starts a frame when idle
- layer_regs  in  NUM_LAYERS*128  flattened layer register file; layer i at [i*128+127:i*128]
- alu_rdy  in  1  rdy from address calculation unit
- out_ready  in  1  downstream accepts slot
- pipeline_clk  out  1  high while slot calculates; low forces address units to restart
- layer_regs_sel  out  128  register word of current layer (combinational mux of live layer_regs by layer_idx)
- x_pixel  out  X_DEPTH+1  current pixel x
- y_pixel  out  Y_DEPTH+1  current pixel y
- layer_idx  out  L_W  current layer
- out_valid  out  1  slot result ready for downstream
- out_last  out  1  with out_valid: last slot of this pixel
- out_bg  out  1  with out_valid: pixel has no enabled layer (background slot)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after final slot accepted

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including pipeline_clk, so address units are held in reset. x, y and layer_idx are 0; enable mask is 0.
- Layer enabled when bit0 (populated) and bit2 (visible) are both 1.
- Enable mask is snapshotted from layer_regs on accepted frame_start and held for the whole frame. Register contents stay live through layer_regs_sel.
- FSM states: IDLE, LOAD, CALC, HAND, DONE.
- IDLE: frame_start=1 -> latch mask; x=0, y=0; layer_idx = lowest enabled layer (0 with bg=1 if mask is 0); go to LOAD.
- LOAD (exactly 1 cycle): pipeline_clk=0, coordinates and layer_idx stable; go to CALC.
- CALC: pipeline_clk=1. Sample alu_rdy only from the 2nd CALC cycle onward, to ignore stale rdy. When alu_rdy=1, go to HAND. For a bg slot, alu_rdy is ignored and the FSM goes to HAND after 1 cycle.
- HAND: pipeline_clk=1, out_valid=1. out_last=1 when no enabled layer above layer_idx; out_bg per slot. Outputs hold until out_ready=1 (accept).
- On accept, if not out_last: layer_idx = next enabled layer above current; go to LOAD.
- On accept with out_last:
  - x == HOR_PIX-1 and y == VER_PIX-1 -> DONE.
  - else x == HOR_PIX-1 -> x=0, y+1.
  - else x+1.
  - layer_idx = lowest enabled layer; go to LOAD.
- DONE (1 cycle): frame_done=1, busy=0, pipeline_clk=0; go to IDLE.
- busy = 1 in LOAD, CALC and HAND.
- Minimum slot cost is 4 cycles (LOAD, 2x CALC, HAND with out_ready high).
- frame_start while not IDLE is ignored; no queuing.
- out_valid rises only in HAND. Once raised it is not withdrawn until accept, even if alu_rdy drops.
- rst asserted mid-frame: immediate return to IDLE with reset values; no frame_done.
- Coordinate counters never exceed HOR_PIX-1 / VER_PIX-1.

Decomposition:
- Package gpu_sched_pkg holds:
  - state enum sched_state_t {IDLE, LOAD, CALC, HAND, DONE}
  - LR_POPULATED_BIT=0, LR_SPRITE_BIT=1, LR_VISIBLE_BIT=2
  - LAYER_REG_W=128
- Sub-module layer_priority_finder (combinational). Inputs: mask[NUM_LAYERS], start index, include-start flag. Outputs: found, index of the first enabled layer at or above start, and "no further layer above index".

Test Plan:
(Bench parameters: HOR_PIX=4, VER_PIX=2, NUM_LAYERS=4.)
- All layers disabled, frame_start, out_ready=1 -> 8 slots, each out_bg=1, out_last=1, layer_idx=0. Coordinates run (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1). frame_done pulses once; 32 cycles from LOAD to last accept.
- Layers 1 and 3 enabled (bits 0,2 set), alu_rdy=1 -> per pixel, slots with layer_idx 1 (out_last=0) then 3 (out_last=1). layer_regs_sel equals layer_regs[511:384] in the layer-3 slot. 16 slots total.
- alu_rdy held 0 for 5 CALC cycles, then 1 -> pipeline_clk stays 1, out_valid stays 0 until alu_rdy=1, then HAND. A single LOAD cycle has pipeline_clk=0 before each slot.
- out_ready held 0 for 3 cycles in HAND -> out_valid, x_pixel, y_pixel, layer_idx and out_last stable for all 4 cycles. Advance occurs only on the cycle with out_ready=1.
- Mask snapshot: enable layer 2 mid-frame -> ignored until next frame. frame_start pulsed while busy -> no effect on counters.
- rst=0 asynchronously at pixel (2,1) -> outputs 0 on the same edge, no frame_done. Next frame_start restarts at (0,0).
